// File: rtl/axis_burst_framer.sv
// Burst framer: prepends a header beat (sync word, sequence number, capture
// timestamp, nominal length) to each 256-bit AXI-stream burst and truncates
// bursts longer than BURST_LENGTH payload beats.
module axis_burst_framer #(
  parameter int CHANNEL_WIDTH = 64,
  parameter int BURST_LENGTH  = 32,
  parameter int TS_WIDTH      = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [4*CHANNEL_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [4*CHANNEL_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [15:0]                frame_count,
  output logic [15:0]                trunc_count
);

  localparam int DATA_W = 4 * CHANNEL_WIDTH;
  localparam int CNT_W  = $clog2(BURST_LENGTH) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic                m_valid_reg, m_valid_next;
  logic [DATA_W-1:0]   m_data_reg, m_data_next;
  logic                m_last_reg, m_last_next;
  logic [TS_WIDTH-1:0] ts_reg, ts_next;
  logic [15:0]         seq_reg, seq_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [15:0]         frame_count_reg, frame_count_next;
  logic [15:0]         trunc_count_reg, trunc_count_next;

  logic                slot_free;
  logic                at_limit;
  logic                s_ready;
  logic [DATA_W-1:0]   header_beat;

  // The output slot may take a new beat when empty or being drained this cycle.
  assign slot_free = ~m_valid_reg | m_axis_tready;
  assign at_limit  = (count_reg == CNT_W'(BURST_LENGTH - 1));

  // Timestamp is the value of the free-running counter in the decision cycle.
  assign header_beat = DATA_W'({16'hFACE, seq_reg, 48'(ts_reg),
                                16'(BURST_LENGTH), 160'd0});

  always_comb begin
    state_next       = state_reg;
    m_valid_next     = m_valid_reg;
    m_data_next      = m_data_reg;
    m_last_next      = m_last_reg;
    ts_next          = ts_reg + 1'b1;
    seq_next         = seq_reg;
    count_next       = count_reg;
    frame_count_next = frame_count_reg;
    trunc_count_next = trunc_count_reg;
    s_ready          = 1'b0;

    // A consumed beat empties the slot unless something reloads it below.
    if (slot_free) begin
      m_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (s_axis_tvalid && slot_free) begin
          m_valid_next = 1'b1;
          m_data_next  = header_beat;
          m_last_next  = 1'b0;
          seq_next     = seq_reg + 16'd1;
          count_next   = '0;
          state_next   = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        s_ready = slot_free;
        if (s_axis_tvalid && slot_free) begin
          m_valid_next = 1'b1;
          m_data_next  = s_axis_tdata;
          m_last_next  = s_axis_tlast | at_limit;
          count_next   = count_reg + 1'b1;
          if (s_axis_tlast) begin
            state_next       = ST_IDLE;
            frame_count_next = frame_count_reg + 16'd1;
          end else if (at_limit) begin
            state_next       = ST_DRAIN;
            frame_count_next = frame_count_reg + 16'd1;
            trunc_count_next = trunc_count_reg + 16'd1;
          end
        end
      end

      ST_DRAIN: begin
        // Excess beats are swallowed until the upstream burst ends.
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      m_valid_reg     <= 1'b0;
      m_data_reg      <= '0;
      m_last_reg      <= 1'b0;
      ts_reg          <= '0;
      seq_reg         <= '0;
      count_reg       <= '0;
      frame_count_reg <= '0;
      trunc_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      m_valid_reg     <= m_valid_next;
      m_data_reg      <= m_data_next;
      m_last_reg      <= m_last_next;
      ts_reg          <= ts_next;
      seq_reg         <= seq_next;
      count_reg       <= count_next;
      frame_count_reg <= frame_count_next;
      trunc_count_reg <= trunc_count_next;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tlast  = m_last_reg;
  assign frame_count   = frame_count_reg;
  assign trunc_count   = trunc_count_reg;

endmodule

// File: tb/tb_axis_burst_framer.sv
// Randomized bench for axis_burst_framer: bursts are turned into expected
// frames by a queue-based model and compared beat by beat on the output.
module tb_axis_burst_framer;

  localparam int BL = 32;

  logic         clk;
  logic         rst_n;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [255:0] s_axis_tdata;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [15:0]  frame_count;
  logic [15:0]  trunc_count;

  axis_burst_framer #(.CHANNEL_WIDTH(64), .BURST_LENGTH(BL), .TS_WIDTH(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .frame_count(frame_count), .trunc_count(trunc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic         last;
    bit           is_hdr;
    bit           ts_set;
  } exp_t;

  typedef struct {
    logic [255:0] data;
    logic         last;
  } in_t;

  exp_t exp_q[$];
  in_t  in_q[$];
  int n_cmp, n_fail;
  int tb_cyc, seq_model, frame_model, trunc_model;
  int out_beats, pay_beats, rdy_pct, gap_pct;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected frame: header, then at most BL payload beats, tlast on the final kept beat.
  task automatic push_burst(input int len);
    exp_t e;
    in_t  b;
    e.data   = {16'hFACE, 16'(seq_model), 48'd0, 16'(BL), 160'd0};
    e.last   = 1'b0;
    e.is_hdr = 1'b1;
    e.ts_set = 1'b0;
    exp_q.push_back(e);
    seq_model++;
    for (int i = 0; i < len; i++) begin
      b.data = rand256();
      b.last = (i == len - 1);
      in_q.push_back(b);
      if (i < BL) begin
        e.data   = b.data;
        e.last   = (i == len - 1) || (i == BL - 1);
        e.is_hdr = 1'b0;
        exp_q.push_back(e);
      end
    end
    frame_model++;
    if (len > BL) trunc_model++;
  endtask

  // One clock: observe handshakes, check the output slot, then drive new inputs.
  task automatic run_cycle();
    logic s_acc, m_hs, pv, pl;
    logic [255:0] pd;
    exp_t e;
    @(negedge clk);
    s_acc = s_axis_tvalid & s_axis_tready;
    m_hs  = m_axis_tvalid & m_axis_tready;
    pv = m_axis_tvalid;
    pd = m_axis_tdata;
    pl = m_axis_tlast;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      tb_cyc = 0;
      exp_q.delete();
      in_q.delete();
      seq_model = 0;
      frame_model = 0;
      trunc_model = 0;
      s_axis_tvalid = 1'b0;
    end else begin
      tb_cyc++;
      if (m_hs) begin
        out_beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data=%h last=%b, required no beat", pd[63:0], pl);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_hdr) pay_beats++;
          $display("beat %0d hdr=%0d last=%0b data[255:160]=%h data[63:0]=%h",
                   out_beats, e.is_hdr, pl, pd[255:160], pd[63:0]);
          if ({pd, pl} !== {e.data, e.last}) begin
            n_fail++;
            $display("FAIL beat_%0d: got %h/%h last=%b, required %h/%h last=%b", out_beats,
                     pd[255:160], pd[63:0], pl, e.data[255:160], e.data[63:0], e.last);
          end
        end
      end else if (pv) begin
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, pd, pl}) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, required 1/%h/%b",
                   m_axis_tvalid, m_axis_tdata[63:0], m_axis_tlast, pd[63:0], pl);
        end
      end
      // A freshly presented header was decided one cycle ago: its ts is that cycle's count.
      if (m_axis_tvalid && (m_hs || !pv) && exp_q.size() > 0 &&
          exp_q[0].is_hdr && !exp_q[0].ts_set) begin
        e = exp_q[0];
        e.data[223:176] = 48'(tb_cyc - 1);
        e.ts_set = 1'b1;
        exp_q[0] = e;
      end
      if (s_acc && in_q.size() > 0) void'(in_q.pop_front());
      if (!(s_axis_tvalid && !s_acc)) begin
        s_axis_tvalid = (in_q.size() > 0) && ($urandom_range(99) >= gap_pct);
      end
      if (in_q.size() > 0) begin
        s_axis_tdata = in_q[0].data;
        s_axis_tlast = in_q[0].last;
      end
    end
    m_axis_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0 || m_axis_tvalid) && n < 3000) begin
      run_cycle();
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (2) run_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy_pct = 100;
    gap_pct = 0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    repeat (3) run_cycle();
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready} !== 3'b000 || m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b rdy=%b d=%h, required 0/0/0/0",
               m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tdata[63:0]);
    end
    n_cmp++;
    if (frame_count !== 16'd0 || trunc_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d, required 0/0", frame_count, trunc_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    push_burst(32);
    drain("single");
    n_cmp++;
    if (frame_count !== 16'(frame_model) || trunc_count !== 16'(trunc_model)) begin
      n_fail++;
      $display("FAIL single_counts: got %0d/%0d, required %0d/%0d",
               frame_count, trunc_count, frame_model, trunc_model);
    end
  endtask

  task automatic test_back_to_back();
    out_beats = 0;
    push_burst(32);
    push_burst(32);
    drain("b2b");
    n_cmp++;
    if (out_beats != 66) begin
      n_fail++;
      $display("FAIL b2b_beats: got %0d, required 66", out_beats);
    end
    n_cmp++;
    if (frame_count !== 16'(frame_model)) begin
      n_fail++;
      $display("FAIL b2b_frames: got %0d, required %0d", frame_count, frame_model);
    end
  endtask

  task automatic test_truncation();
    push_burst(40);
    drain("trunc");
    n_cmp++;
    if (trunc_count !== 16'(trunc_model) || frame_count !== 16'(frame_model)) begin
      n_fail++;
      $display("FAIL trunc_counts: got %0d/%0d, required %0d/%0d",
               trunc_count, frame_count, trunc_model, frame_model);
    end
    n_cmp++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL trunc_idle_ready: got %b, required 0", s_axis_tready);
    end
  endtask

  task automatic test_short_burst();
    push_burst(10);
    drain("short");
    n_cmp++;
    if (trunc_count !== 16'(trunc_model) || frame_count !== 16'(frame_model)) begin
      n_fail++;
      $display("FAIL short_counts: got %0d/%0d, required %0d/%0d",
               trunc_count, frame_count, trunc_model, frame_model);
    end
  endtask

  task automatic test_backpressure();
    rdy_pct = 50;
    gap_pct = 20;
    for (int b = 0; b < 4; b++) push_burst($urandom_range(1, 40));
    drain("bp");
    rdy_pct = 100;
    gap_pct = 0;
    n_cmp++;
    if (trunc_count !== 16'(trunc_model) || frame_count !== 16'(frame_model)) begin
      n_fail++;
      $display("FAIL bp_counts: got %0d/%0d, required %0d/%0d",
               trunc_count, frame_count, trunc_model, frame_model);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    push_burst(32);
    pay_beats = 0;
    while (pay_beats < 5 && n < 200) begin
      run_cycle();
      n++;
    end
    n_cmp++;
    if (pay_beats < 5) begin
      n_fail++;
      $display("FAIL midrst_reach: got %0d payload beats, required 5", pay_beats);
    end
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    in_q.delete();
    run_cycle();
    rst_n = 1'b1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valid: got v=%b rdy=%b, required 0/0", m_axis_tvalid, s_axis_tready);
    end
    n_cmp++;
    if (frame_count !== 16'd0 || trunc_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_counts: got %0d/%0d, required 0/0", frame_count, trunc_count);
    end
    push_burst(10);
    drain("midrst");
    n_cmp++;
    if (frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_after: got %0d frames, required 1", frame_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    tb_cyc = 0;
    seq_model = 0;
    frame_model = 0;
    trunc_model = 0;
    out_beats = 0;
    pay_beats = 0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_truncation();
    test_short_burst();
    test_backpressure();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_burst_framer.md
# axis_burst_framer

Quad-channel burst framer sitting directly downstream of the peak detector. It consumes the detector's 256-bit AXI-stream bursts, one burst per detected peak, normally BURST_LENGTH beats closed by tlast. Each burst goes out with one prepended header beat carrying a sync word, sequence number, capture timestamp and nominal length. Over-length bursts are truncated so the host-side DMA always sees bounded, self-describing frames.

## Interface
- CHANNEL_WIDTH, 64, bits per channel; data width is 4*CHANNEL_WIDTH.
- BURST_LENGTH, 32, maximum payload beats per frame (≥2).
- TS_WIDTH, 48, timestamp width (≤48).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  1  payload beat valid.
- s_axis_tready  out  1  payload beat ready.
- s_axis_tdata  in  256  four channels, ch0 in [63:0].
- s_axis_tlast  in  1  end of burst.
- m_axis_tvalid  out  1  framed beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  256  header or payload beat.
- m_axis_tlast  out  1  last beat of frame.
- frame_count  out  16  frames emitted; wraps.
- trunc_count  out  16  frames truncated at BURST_LENGTH; wraps.

## Operation
- Output register: m_axis_tvalid/tdata/tlast registered. The slot is free when ~m_axis_tvalid | m_axis_tready. It loads a new beat only when free; otherwise it holds all values.
- ts: free-running TS_WIDTH counter, +1 every cycle with rst_n high, wraps to 0.
- seq: 16-bit header sequence number, +1 per header loaded, wraps.
- Header beat fields:
  - [255:240] = 16'hFACE
  - [239:224] = seq before increment
  - [223:176] = ts, zero-extended
  - [175:160] = BURST_LENGTH
  - [159:0] = 0
  - tlast = 0
- State IDLE:
  - s_axis_tready = 0.
  - If s_axis_tvalid and slot free: load header, capture ts of that cycle, beat count := 0, go PAYLOAD.
- State PAYLOAD:
  - s_axis_tready = slot free. This is a combinational path from m_axis_tready, by design.
  - On accept: load data and set m_axis_tlast = s_axis_tlast | (count == BURST_LENGTH-1); count +1.
  - Accept with s_axis_tlast: go IDLE, frame_count +1.
  - Accept at count == BURST_LENGTH-1 without tlast: go DRAIN, frame_count +1, trunc_count +1.
  - s_axis_tvalid low mid-burst: wait in PAYLOAD indefinitely; no timeout.
- State DRAIN:
  - s_axis_tready = 1; accepted beats are discarded.
  - Accepted beat with tlast: go IDLE.
  - Output register unaffected.
- Short burst (tlast before BURST_LENGTH): forwarded unchanged. Header still reports BURST_LENGTH. Not counted as truncation.
- Beat count width: clog2(BURST_LENGTH) + 1.

## Timing
- Reset (rst_n low at an edge):
  - state IDLE.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - s_axis_tready = 0.
  - ts, seq, count, frame_count, trunc_count = 0.
- Reset mid-frame abandons the frame: no tlast is emitted and the next frame starts with seq 0.
- Header latency:
  - s_axis_tvalid seen in IDLE at cycle N with slot free: header valid on m_axis at N+1.
  - First payload beat accepted at N+1 at the earliest and presented at N+2.
- Payload latency: 1 cycle from s-side accept to m_axis_tvalid.
- Throughput: 1 beat/cycle in PAYLOAD with m_axis_tready held high. Overhead is 1 cycle per frame (the header) plus the IDLE decision.
- Back-to-back: a burst starting the cycle after a tlast accept gets its header decided in IDLE that cycle, so there is no beat loss. The upstream stream stalls via s_axis_tready = 0.
- m_axis_tready low: tvalid, tdata and tlast hold stable; no s-side accept occurs (except in DRAIN).
- Simultaneous tlast and count == BURST_LENGTH-1: treated as a normal end, going IDLE with no truncation.

## Test plan
- Reset, then a 32-beat burst with tlast on beat 32, m_axis_tready = 1 -> header with FACE, seq 0, ts = capture cycle, length 32. Then 32 payload beats in order, tlast on beat 32 only. frame_count = 1, trunc_count = 0.
- Two back-to-back 32-beat bursts -> headers with seq 0 then 1; 66 output beats; no payload lost or duplicated.
- 40-beat burst, tlast on beat 40 -> 32 payload beats output with tlast on 32nd; beats 33–40 dropped. trunc_count = 1, then IDLE.
- 10-beat burst with tlast on beat 10 -> header with length 32, 10 payload beats, tlast on 10th, trunc_count = 0.
- Random m_axis_tready (50%) over 4 bursts -> output stable while stalled; frame data matches a scoreboard.
- rst_n low for 1 cycle at payload beat 5 -> m_axis_tvalid = 0 next cycle, counters 0. The next burst's header has seq 0 and ts counted from reset release.
